// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   INST_W        : instruction word width
//   PC_STEP       : byte distance between consecutive instructions
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam int unsigned INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage.
//   imem_* : single-outstanding instruction-memory read port
//   if_*   : fetched instruction presented to the datapath (valid/ready)
//   id_ready/pc_src/branch_imm/jmp : datapath consume + redirect outcome
//   fault  : sticky bus-error indication
// modport master : the fetch unit; modport slave : memory + datapath side.
interface fetch_unit_if #(
  parameter int unsigned AW = 32
);
  import fetch_pkg::*;

  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              imem_err;

  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [31:0]       if_pc;
  logic [31:0]       if_pc_plus4;

  logic              id_ready;
  logic              pc_src;
  logic [31:0]       branch_imm;
  logic              jmp;

  logic              fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata, imem_err,
    output if_valid, if_inst, if_pc, if_pc_plus4,
    input  id_ready, pc_src, branch_imm, jmp,
    output fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata, imem_err,
    input  if_valid, if_inst, if_pc, if_pc_plus4,
    output id_ready, pc_src, branch_imm, jmp,
    input  fault
  );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection for the consumed instruction.
//   pc_plus4   : address of the consumed instruction + 4
//   inst       : low 26 bits of the consumed instruction (jump index)
//   branch_imm : sign-extended word offset for a taken branch
//   pc_src     : taken branch
//   jmp        : jump (wins over pc_src)
//   next_pc    : address of the next instruction to fetch
module next_pc (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] inst,
  input  logic [31:0] branch_imm,
  input  logic        pc_src,
  input  logic        jmp,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (jmp) begin
      // Region comes from pc+4, not pc.
      next_pc = {pc_plus4[31:28], inst, 2'b00};
    end else if (pc_src) begin
      // Shifting in 32 bits drops imm[31:30]; the add wraps mod 2^32.
      next_pc = pc_plus4 + (branch_imm << 2);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one imem read at a time,
// presents the fetched word to the datapath and redirects on consume.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : fetch_unit_if.master (imem port, if_* handshake, fault)
// Parameters: RESET_PC (word-aligned reset PC), AW (imem address width).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;

  logic [31:0]       pc;
  logic [INST_W-1:0] if_inst_q;
  logic [31:0]       if_pc_q;
  logic [31:0]       if_pc_plus4_q;
  logic [31:0]       next_pc_w;

  logic              rsp_ok;
  logic              consume;

  // A response only counts while a request is outstanding; a consume only
  // counts while an instruction is held.
  assign rsp_ok  = (state == FETCH) && bus.imem_rvalid && !bus.imem_err;
  assign consume = (state == HOLD) && bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (bus.imem_rvalid) begin
          state_nxt = bus.imem_err ? FAULT : HOLD;
        end
      end
      HOLD:  begin
        if (bus.id_ready) begin
          state_nxt = FETCH;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state == FETCH);
    bus.imem_addr   = pc[AW-1:0];
    bus.if_valid    = (state == HOLD);
    bus.fault       = (state == FAULT);
    bus.if_inst     = if_inst_q;
    bus.if_pc       = if_pc_q;
    bus.if_pc_plus4 = if_pc_plus4_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      if_inst_q     <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else begin
      if (rsp_ok) begin
        if_inst_q     <= bus.imem_rdata;
        if_pc_q       <= pc;
        if_pc_plus4_q <= pc + PC_STEP;
      end
      if (consume) begin
        pc <= next_pc_w;
      end
    end
  end

  next_pc u_next_pc (
    .pc_plus4   (if_pc_plus4_q),
    .inst       (if_inst_q[25:0]),
    .branch_imm (bus.branch_imm),
    .pc_src     (bus.pc_src),
    .jmp        (bus.jmp),
    .next_pc    (next_pc_w)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers fetches, a
// datapath model consumes with random redirects, and a monitor compares
// every held/consumed instruction and every fetch address against a
// behavioural model of the PC sequence.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int unsigned lat;
    int unsigned hold;
    bit          ps;
    bit          j;
    logic [31:0] imm;
  } dir_t;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.AW(32)) bus ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .AW       (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   n_cons = 0;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  dir_t        dir_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                             input bit ps, input bit j, input logic [31:0] imm);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
    if (ps) return p4 + imm * 32'd4;
    return p4;
  endfunction

  function automatic dir_t mk(input logic [31:0] data, input bit err, input int unsigned lat,
                              input int unsigned hold, input bit ps, input bit j,
                              input logic [31:0] imm);
    dir_t d;
    d.data = data; d.err = err; d.lat = lat; d.hold = hold;
    d.ps = ps; d.j = j; d.imm = imm;
    return d;
  endfunction

  // Instruction memory model: one request at a time, latency >= 1 cycle.
  bit          busy = 0;
  int unsigned cnt  = 0;
  logic [31:0] cur_pc = '0;

  always @(negedge clk) begin
    logic [31:0] d;
    bit          e;
    bus.imem_rvalid = 1'b0;
    bus.imem_err    = 1'b0;
    if (!rst_n) begin
      busy = 0;
    end else if (busy) begin
      if (cnt > 1) begin
        cnt--;
      end else begin
        d = (dir_q.size() != 0) ? dir_q[0].data : $urandom;
        e = (dir_q.size() != 0) ? dir_q[0].err : 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        bus.imem_err    = e;
        if (!e) exp_q.push_back('{inst: d, pc: cur_pc});
        busy = 0;
      end
    end else if (bus.imem_req) begin
      busy = 1;
      cnt  = (dir_q.size() != 0) ? dir_q[0].lat : $urandom_range(3, 1);
      if (addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL fetch_addr: got %h want none (model queue empty)", bus.imem_addr);
        cur_pc = bus.imem_addr;
      end else begin
        cur_pc = addr_q.pop_front();
        chk("fetch_addr", bus.imem_addr, cur_pc);
      end
    end else if ((dir_q.size() != 0) ? (dir_q[0].hold != 0) : ($urandom_range(3, 0) == 0)) begin
      // Stray response while nothing is outstanding; must be ignored.
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom;
      bus.imem_err    = 1'($urandom_range(1, 0));
    end
  end

  // Datapath consumer model.
  int unsigned wait_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.id_ready = 1'b0;
      bus.pc_src   = 1'b0;
      bus.jmp      = 1'b0;
      wait_cnt     = 0;
    end else if (bus.if_valid && dir_q.size() != 0) begin
      if (wait_cnt < dir_q[0].hold) begin
        bus.id_ready   = 1'b0;
        bus.pc_src     = 1'b1;
        bus.jmp        = 1'b1;
        bus.branch_imm = $urandom;
        wait_cnt++;
      end else begin
        bus.id_ready   = 1'b1;
        bus.pc_src     = dir_q[0].ps;
        bus.jmp        = dir_q[0].j;
        bus.branch_imm = dir_q[0].imm;
        void'(dir_q.pop_front());
        wait_cnt = 0;
      end
    end else begin
      bus.id_ready   = 1'($urandom_range(1, 0));
      bus.pc_src     = ($urandom_range(3, 0) == 0);
      bus.jmp        = ($urandom_range(3, 0) == 0);
      bus.branch_imm = $urandom;
    end
  end

  // Monitor: compares held/consumed instruction against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.if_valid) begin
      chk("hold_req", 32'(bus.imem_req), 32'd0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL if_valid: got 1 want 0 (no instruction expected)");
      end else if (bus.id_ready) begin
        e = exp_q.pop_front();
        chk("if_inst", bus.if_inst, e.inst);
        chk("if_pc", bus.if_pc, e.pc);
        chk("if_pc_plus4", bus.if_pc_plus4, e.pc + 32'd4);
        addr_q.push_back(model_next(e.pc, e.inst, bus.pc_src, bus.jmp, bus.branch_imm));
        n_cons++;
      end else begin
        chk("hold_inst", bus.if_inst, exp_q[0].inst);
        chk("hold_pc", bus.if_pc, exp_q[0].pc);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_inst", bus.if_inst, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_pc4", bus.if_pc_plus4, 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
  endtask

  // Called at negedge+3 with rst_n already low: restart the models.
  task automatic restart_models();
    @(negedge clk);
    #3;
    exp_q.delete();
    addr_q.delete();
    dir_q.delete();
    addr_q.push_back(RESET_PC);
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  task automatic run_consumes(input int n, input string name);
    int target;
    int cyc;
    target = n_cons + n;
    cyc = 0;
    while (n_cons < target && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (n_cons < target) begin
      total++; bad++;
      $display("FAIL %s: got %0d consumes want %0d (timeout)", name, n_cons, target);
    end
  endtask

  initial begin
    logic [31:0] imm_far;
    int          cyc;
    rst_n           = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.imem_err    = 1'b0;
    bus.id_ready    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.jmp         = 1'b0;
    bus.branch_imm  = '0;
    addr_q.push_back(RESET_PC);

    imm_far = (32'hFFFF_FFFC - 32'h1000_0404) >> 2;
    dir_q.push_back(mk(32'h2008_0005, 0, 2, 0, 0, 0, 32'h0));          // @0 -> 4
    dir_q.push_back(mk(32'h0000_0013, 0, 1, 0, 1, 0, 32'd14));         // @4 -> 0x40
    dir_q.push_back(mk(32'h1234_5678, 0, 3, 0, 1, 0, 32'hFFFF_FFFE)); // @0x40 -> 0x3C
    dir_q.push_back(mk(32'hABCD_0001, 0, 1, 5, 1, 0, 32'h03FF_FFF4)); // @0x3C hold 5 -> 0x1000_0010
    dir_q.push_back(mk(32'h0800_0100, 0, 2, 0, 1, 1, 32'h0000_1234)); // jmp wins -> 0x1000_0400
    dir_q.push_back(mk(32'h0000_0000, 0, 1, 0, 1, 0, imm_far));        // -> 0xFFFF_FFFC
    dir_q.push_back(mk(32'hFFFF_FFFF, 0, 1, 0, 0, 0, 32'h0));          // wrap -> 0
    dir_q.push_back(mk(32'hDEAD_BEEF, 1, 2, 0, 0, 0, 32'h0));          // bus error

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    #2;
    rst_n = 1'b1;

    cyc = 0;
    while (!bus.fault && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("fault_seen", 32'(bus.fault), 32'd1);
    chk("dir_left", 32'(dir_q.size()), 32'd1);
    chk("dir_consumes", 32'(n_cons), 32'd7);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("fault_sticky", 32'(bus.fault), 32'd1);
      chk("fault_req", 32'(bus.imem_req), 32'd0);
      chk("fault_valid", 32'(bus.if_valid), 32'd0);
    end

    @(negedge clk);
    #3;
    rst_n = 1'b0;
    restart_models();
    run_consumes(300, "random_run");

    // Reset while a request is outstanding.
    cyc = 0;
    do begin
      @(negedge clk);
      #3;
      cyc++;
    end while (!bus.imem_req && cyc < 100);
    chk("midfetch_req_before", 32'(bus.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midfetch_req_drop", 32'(bus.imem_req), 32'd0);
    #1;
    restart_models();
    run_consumes(30, "restart_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
